// File: rtl/tile_board.sv
// Seven-row falling-tile board: shifts rows once per step period, feeds new top
// rows from an LFSR, hands line_6 to the key checker and decides game over.
//
// state  | meaning
// S_IDLE | after reset, waiting for start
// S_RUN  | game in progress, rows advancing
// S_OVER | wrong key or missed tile, rows frozen until start
module tile_board #(
  parameter int unsigned TICK_DIV  = 32'd25_000_000,
  parameter int unsigned TICK_MIN  = 32'd5_000_000,
  parameter int unsigned TICK_DEC  = 32'd1_000_000,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       check_input_done,
  input  logic       correct,
  input  logic       incorrect,
  output logic [2:0] line_0,
  output logic [2:0] line_1,
  output logic [2:0] line_2,
  output logic [2:0] line_3,
  output logic [2:0] line_4,
  output logic [2:0] line_5,
  output logic [2:0] line_6,
  output logic       check_input_go,
  output logic       step,
  output logic       hit,
  output logic       game_over
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [6:0][2:0]   rows;
  logic [7:0]        lfsr;
  logic              lfsr_fb;
  logic [31:0]       period;
  logic [31:0]       period_dec;
  logic [31:0]       tick_cnt;
  logic [3:0]        hit_cnt;
  logic              resolved;
  logic              running;
  logic              go_int;
  logic              res_correct;
  logic              res_wrong;
  logic              at_tick;
  logic              miss;
  logic              shift;
  logic              enter_run;
  logic [2:0]        new_row;

  assign running     = (state == S_RUN);
  assign go_int      = running && (rows[6] != 3'b000) && !resolved;
  assign res_correct = go_int && check_input_done && correct;
  assign res_wrong   = go_int && check_input_done && !correct && incorrect;
  // >= keeps the boundary reachable if a speed-up lands late in a period
  assign at_tick     = running && (tick_cnt >= (period - 32'd1));
  assign miss        = at_tick && go_int && !res_correct;
  assign shift       = at_tick && !res_wrong && !miss;
  assign enter_run   = (state != S_RUN) && start;

  assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign new_row    = {1'b0, lfsr[1:0]} + 3'd1;
  assign period_dec = ((period - TICK_MIN) >= TICK_DEC) ? (period - TICK_DEC) : TICK_MIN;

  assign line_0 = rows[0];
  assign line_1 = rows[1];
  assign line_2 = rows[2];
  assign line_3 = rows[3];
  assign line_4 = rows[4];
  assign line_5 = rows[5];
  assign line_6 = rows[6];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (res_wrong || miss) state_nxt = S_OVER;
      S_OVER:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    check_input_go = go_int;
    step           = shift;
    game_over      = (state == S_OVER);
  end

  // The LFSR is deliberately not reloaded on start so each game differs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rows     <= '0;
      lfsr     <= LFSR_SEED;
      period   <= TICK_DIV;
      tick_cnt <= 32'd0;
      hit_cnt  <= 4'd0;
      resolved <= 1'b0;
      hit      <= 1'b0;
    end else begin
      hit <= res_correct;
      if (enter_run) begin
        rows     <= '0;
        period   <= TICK_DIV;
        tick_cnt <= 32'd0;
        hit_cnt  <= 4'd0;
        resolved <= 1'b0;
      end else if (running && !res_wrong && !miss) begin
        if (res_correct) begin
          hit_cnt <= hit_cnt + 4'd1;
          if (hit_cnt == 4'hF) begin
            period <= period_dec;
          end
        end
        if (shift) begin
          rows     <= {rows[5:0], new_row};
          lfsr     <= {lfsr[6:0], lfsr_fb};
          resolved <= 1'b0;
          tick_cnt <= 32'd0;
        end else begin
          tick_cnt <= tick_cnt + 32'd1;
          if (res_correct) begin
            rows[6]  <= 3'b000;
            resolved <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tile_board.sv
// Bench for tile_board: a game-level reference model checked every cycle,
// plus directed scenarios with hand-derived tile values and timing.
module tb_tile_board;

  localparam int unsigned TICK_DIV = 40;
  localparam int unsigned TICK_MIN = 15;
  localparam int unsigned TICK_DEC = 10;
  localparam logic [7:0]  SEED     = 8'hA5;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_OVER = 2;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic check_input_done = 1'b0;
  logic correct = 1'b0;
  logic incorrect = 1'b0;
  logic [2:0] line_0, line_1, line_2, line_3, line_4, line_5, line_6;
  logic check_input_go, step, hit, game_over;

  tile_board #(
    .TICK_DIV (TICK_DIV),
    .TICK_MIN (TICK_MIN),
    .TICK_DEC (TICK_DEC),
    .LFSR_SEED(SEED)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .start           (start),
    .check_input_done(check_input_done),
    .correct         (correct),
    .incorrect       (incorrect),
    .line_0          (line_0),
    .line_1          (line_1),
    .line_2          (line_2),
    .line_3          (line_3),
    .line_4          (line_4),
    .line_5          (line_5),
    .line_6          (line_6),
    .check_input_go  (check_input_go),
    .step            (step),
    .hit             (hit),
    .game_over       (game_over)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail = 0;
  int n_steps = 0;
  int since_step = 0;
  int last_int = 0;
  bit seen30 = 0, seen20 = 0, seen15 = 0;

  // reference model: game state in plain terms
  int         m_state = M_IDLE;
  logic [2:0] m_row [7];
  logic [7:0] m_lfsr = SEED;
  int         m_period = TICK_DIV;
  int         m_cnt = 0;
  int         m_hits = 0;
  bit         m_resolved = 0;
  bit         m_hit = 0;

  function automatic bit m_go();
    return (m_state == M_RUN) && (m_row[6] != 3'd0) && !m_resolved;
  endfunction

  function automatic bit m_step();
    bit c, w, bnd;
    c   = m_go() && check_input_done && correct;
    w   = m_go() && check_input_done && !correct && incorrect;
    bnd = (m_state == M_RUN) && (m_cnt + 1 >= m_period);
    return bnd && !w && !(m_go() && !c);
  endfunction

  task automatic model_update();
    bit go_v, c_v, w_v, bnd_v;
    if (!resetn) begin
      m_state = M_IDLE;
      for (int k = 0; k < 7; k++) m_row[k] = 3'd0;
      m_lfsr = SEED; m_period = TICK_DIV; m_cnt = 0; m_hits = 0;
      m_resolved = 0; m_hit = 0;
    end else begin
      go_v  = m_go();
      c_v   = go_v && check_input_done && correct;
      w_v   = go_v && check_input_done && !correct && incorrect;
      bnd_v = (m_state == M_RUN) && (m_cnt + 1 >= m_period);
      m_hit = 0;
      if (m_state != M_RUN) begin
        if (start) begin
          m_state = M_RUN;
          for (int k = 0; k < 7; k++) m_row[k] = 3'd0;
          m_period = TICK_DIV; m_cnt = 0; m_hits = 0; m_resolved = 0;
        end
      end else if (w_v) begin
        m_state = M_OVER;
      end else begin
        if (c_v) begin
          m_hit = 1; m_hits++; m_row[6] = 3'd0; m_resolved = 1;
          if (m_hits % 16 == 0)
            m_period = (m_period - TICK_DEC < TICK_MIN) ? TICK_MIN : m_period - TICK_DEC;
        end
        if (bnd_v) begin
          if (m_row[6] != 3'd0 && !m_resolved) begin
            m_state = M_OVER;
          end else begin
            for (int k = 6; k > 0; k--) m_row[k] = m_row[k-1];
            m_row[0] = 3'((m_lfsr % 8'd4) + 8'd1);
            m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
            m_resolved = 0; m_cnt = 0;
          end
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clock or negedge resetn);
    model_update();
  end

  initial forever begin
    logic [24:0] exp_v, act_v;
    @(negedge clock);
    exp_v = {m_row[6], m_row[5], m_row[4], m_row[3], m_row[2], m_row[1], m_row[0],
             m_go(), m_step(), m_hit, (m_state == M_OVER)};
    act_v = {line_6, line_5, line_4, line_3, line_2, line_1, line_0,
             check_input_go, step, hit, game_over};
    n_assert++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t got=%h expected=%h", $time, act_v, exp_v);
    end
    since_step++;
    if (step === 1'b1) begin
      n_steps++;
      last_int = since_step;
      if (since_step == 30) seen30 = 1;
      if (since_step == 20) seen20 = 1;
      if (since_step == 15) seen15 = 1;
      since_step = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  function automatic logic [20:0] dut_rows();
    return {line_6, line_5, line_4, line_3, line_2, line_1, line_0};
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_steps(input int n, input string name);
    int target = n_steps + n;
    int budget = 0;
    while (n_steps < target && budget < 2000) begin
      cyc(1);
      budget++;
    end
    check(name, 32'(n_steps >= target), 32'd1);
  endtask

  task automatic wait_boundary(input string name);
    int budget = 0;
    while (!(m_state == M_RUN && m_cnt + 1 >= m_period) && budget < 200) begin
      cyc(1);
      budget++;
    end
    check(name, 32'(budget < 200), 32'd1);
  endtask

  task automatic wait_over(input string name);
    int budget = 0;
    while (game_over !== 1'b1 && budget < 100) begin
      cyc(1);
      budget++;
    end
    check(name, 32'(game_over), 32'd1);
  endtask

  task automatic freeze_check(input string name);
    logic [20:0] saved = dut_rows();
    int s = n_steps;
    cyc(20);
    check({name, "_rows"}, 32'(dut_rows()), 32'(saved));
    check({name, "_nostep"}, 32'(n_steps), 32'(s));
  endtask

  initial begin
    int s;
    logic [2:0]  saved5;
    logic [20:0] saved_rows;

    cyc(2);
    check("reset_rows", 32'(dut_rows()), 32'd0);
    check("reset_flags", 32'({check_input_go, step, hit, game_over}), 32'd0);
    resetn = 1'b1;
    cyc(2);

    // game 1: LFSR tiles, a hit, then a miss
    pulse_start();
    check("start_rows_empty", 32'(dut_rows()), 32'd0);
    wait_steps(1, "g1_step1");
    check("g1_line0_first", 32'(line_0), 32'd2);
    check("model_line0_first", 32'(m_row[0]), 32'd2);
    wait_steps(6, "g1_step7");
    check("g1_line6_at7", 32'(line_6), 32'd2);
    check("g1_line0_at7", 32'(line_0), 32'd4);
    check("g1_go_at7", 32'(check_input_go), 32'd1);
    check_input_done = 1'b1; correct = 1'b1;
    cyc(1);
    check_input_done = 1'b0; correct = 1'b0;
    check("g1_hit", 32'({hit, line_6, check_input_go}), 32'b1_000_0);
    wait_steps(1, "g1_step8");
    check("g1_no_over_after_hit", 32'(game_over), 32'd0);
    check("g1_line6_at8", 32'(line_6), 32'd3);
    s = n_steps;
    wait_over("g1_miss_over");
    check("g1_miss_line6", 32'(line_6), 32'd3);
    check("g1_miss_nostep", 32'(n_steps), 32'(s));
    freeze_check("g1_freeze");

    // game 2: wrong key
    pulse_start();
    check("g2_restart", 32'({dut_rows(), game_over}), 32'd0);
    wait_steps(7, "g2_step7");
    check("g2_go", 32'(check_input_go), 32'd1);
    check_input_done = 1'b1; incorrect = 1'b1;
    cyc(1);
    check_input_done = 1'b0; incorrect = 1'b0;
    check("g2_wrong_over", 32'(game_over), 32'd1);
    freeze_check("g2_freeze");

    // game 3: both results, unqualified done, results on the step boundary
    pulse_start();
    wait_steps(7, "g3_step7");
    check_input_done = 1'b1; correct = 1'b1; incorrect = 1'b1;
    cyc(1);
    check_input_done = 1'b0; correct = 1'b0; incorrect = 1'b0;
    check("g3_both_is_hit", 32'({hit, game_over}), 32'b10);
    check_input_done = 1'b1; incorrect = 1'b1;
    cyc(1);
    check_input_done = 1'b0; incorrect = 1'b0;
    cyc(1);
    check("g3_unqualified_ignored", 32'(game_over), 32'd0);
    wait_steps(1, "g3_step8");
    wait_boundary("g3_bnd_hit");
    saved5 = line_5;
    check_input_done = 1'b1; correct = 1'b1;
    #4;
    check("g3_bnd_hit_step", 32'(step), 32'd1);
    @(posedge clock); #2;
    check_input_done = 1'b0; correct = 1'b0;
    check("g3_bnd_hit_flags", 32'({hit, game_over}), 32'b10);
    check("g3_bnd_hit_line6", 32'(line_6), 32'(saved5));
    wait_boundary("g3_bnd_wrong");
    saved_rows = dut_rows();
    check_input_done = 1'b1; incorrect = 1'b1;
    #4;
    check("g3_bnd_wrong_nostep", 32'(step), 32'd0);
    @(posedge clock); #2;
    check_input_done = 1'b0; incorrect = 1'b0;
    check("g3_bnd_wrong_over", 32'(game_over), 32'd1);
    check("g3_bnd_wrong_rows", 32'(dut_rows()), 32'(saved_rows));

    // asynchronous reset mid-game
    pulse_start();
    wait_steps(3, "rst_steps");
    resetn = 1'b0;
    #1;
    check("async_rst_rows", 32'(dut_rows()), 32'd0);
    check("async_rst_flags", 32'({check_input_go, step, hit, game_over}), 32'd0);
    cyc(1);
    resetn = 1'b1;
    cyc(1);
    s = n_steps;
    cyc(50);
    check("rst_idle_nostep", 32'(n_steps), 32'(s));
    pulse_start();
    wait_steps(1, "rst_step1");
    check("rst_lfsr_reseeded", 32'(line_0), 32'd2);

    // speed-up: hit every tile
    s = 0;
    while (m_hits < 52 && s < 6000) begin
      check_input_done = check_input_go;
      correct = check_input_go;
      cyc(1);
      s++;
    end
    check_input_done = 1'b0; correct = 1'b0;
    check("speed_hits_reached", 32'(m_hits >= 52), 32'd1);
    check("speed_no_over", 32'(game_over), 32'd0);
    check("model_period_floor", 32'(m_period), 32'd15);
    check("speed_last_interval", 32'(last_int), 32'd15);
    check("speed_seen_30_20_15", 32'({seen30, seen20, seen15}), 32'b111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
